mips_program_loader: RTL and testbench

Byte-stream boot loader that sits directly upstream of the MIPS CPU top. It parses a framed byte stream into 32-bit words and drives the CPU's external instruction-memory and data-memory write ports (ext_instr*/ext_data*). When the host sends the GO command, it pulses the CPU's start input. The CPU core stays idle until the loader has finished.

---
 rtl/mips_program_loader_if.sv | 29 ++
 rtl/mips_program_loader.sv | 189 ++++++++++++++++++
 tb/tb_mips_program_loader.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_program_loader_if.sv
// Byte-stream input and CPU memory-write/control outputs of the boot loader.
// The host side uses master; the loader uses slave.
interface mips_program_loader_if;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ext_instr;
  logic [31:0] ext_instr_addr;
  logic        ext_instr_en;
  logic [31:0] ext_data;
  logic [31:0] ext_data_addr;
  logic        ext_data_en;
  logic        start;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output in_byte, in_valid,
    input  in_ready, ext_instr, ext_instr_addr, ext_instr_en,
           ext_data, ext_data_addr, ext_data_en, start, busy, done, error
  );

  modport slave (
    input  in_byte, in_valid,
    output in_ready, ext_instr, ext_instr_addr, ext_instr_en,
           ext_data, ext_data_addr, ext_data_en, start, busy, done, error
  );
endinterface

// File: rtl/mips_program_loader.sv
// Boot loader: parses framed byte stream into 32-bit words, writes them to the
// CPU instruction/data memories and pulses start on the GO command.
module mips_program_loader #(
  parameter logic [31:0] INSTR_BASE = 32'h0000_0000,
  parameter logic [31:0] DATA_BASE  = 32'h0000_0000,
  parameter int unsigned MAX_WORDS  = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mips_program_loader_if.slave   ldr
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WORD_W = 32;

  localparam logic [7:0] CMD_INSTR = 8'h01;
  localparam logic [7:0] CMD_DATA  = 8'h02;
  localparam logic [7:0] CMD_GO    = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_WORD, S_WRITE, S_GO, S_DONE, S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic                sec_data_q, sec_data_d;
  logic [7:0]          cnt_hi_q, cnt_hi_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    index_q, index_d;
  logic [23:0]         shift_q, shift_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;

  logic                in_ready_q, in_ready_d;
  logic [WORD_W-1:0]   instr_q, instr_d, instr_addr_q, instr_addr_d;
  logic                instr_en_q, instr_en_d;
  logic [WORD_W-1:0]   data_q, data_d, data_addr_q, data_addr_d;
  logic                data_en_q, data_en_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                hs_c;
  logic [CNT_W-1:0]    count_c;
  logic [WORD_W-1:0]   word_c;
  logic [WORD_W-1:0]   addr_c;

  // Handshake is judged against the registered ready the host actually sees.
  assign hs_c    = ldr.in_valid && in_ready_q;
  assign count_c = {cnt_hi_q, ldr.in_byte};
  assign word_c  = {shift_q, ldr.in_byte};
  assign addr_c  = (sec_data_q ? DATA_BASE : INSTR_BASE) + WORD_W'({index_q, 2'b00});

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    sec_data_d   = sec_data_q;
    cnt_hi_d     = cnt_hi_q;
    count_d      = count_q;
    index_d      = index_q;
    shift_d      = shift_q;
    byte_cnt_d   = byte_cnt_q;
    instr_d      = instr_q;
    instr_addr_d = instr_addr_q;
    instr_en_d   = 1'b0;
    data_d       = data_q;
    data_addr_d  = data_addr_q;
    data_en_d    = 1'b0;
    start_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (hs_c) begin
          unique case (ldr.in_byte)
            CMD_INSTR: begin sec_data_d = 1'b0; state_d = S_CNT_HI; end
            CMD_DATA:  begin sec_data_d = 1'b1; state_d = S_CNT_HI; end
            CMD_GO:    begin start_d = 1'b1;    state_d = S_GO;     end
            default:   state_d = S_ERR;
          endcase
        end
      end
      S_CNT_HI: begin
        if (hs_c) begin
          cnt_hi_d = ldr.in_byte;
          state_d  = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (hs_c) begin
          count_d = count_c;
          if (count_c == CNT_W'(0)) begin
            state_d = S_IDLE;
          end else if (32'(count_c) > 32'(MAX_WORDS)) begin
            state_d = S_ERR;
          end else begin
            index_d    = '0;
            byte_cnt_d = '0;
            state_d    = S_WORD;
          end
        end
      end
      S_WORD: begin
        if (hs_c) begin
          shift_d    = {shift_q[15:0], ldr.in_byte};
          byte_cnt_d = 2'(byte_cnt_q + 2'd1);
          if (byte_cnt_q == 2'd3) begin
            state_d = S_WRITE;
            if (sec_data_q) begin
              data_d      = word_c;
              data_addr_d = addr_c;
              data_en_d   = 1'b1;
            end else begin
              instr_d      = word_c;
              instr_addr_d = addr_c;
              instr_en_d   = 1'b1;
            end
          end
        end
      end
      S_WRITE: begin
        index_d = CNT_W'(index_q + CNT_W'(1));
        state_d = (CNT_W'(index_q + CNT_W'(1)) == count_q) ? S_IDLE : S_WORD;
      end
      S_GO:    state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase

    in_ready_d = state_d inside {S_IDLE, S_CNT_HI, S_CNT_LO, S_WORD};
    busy_d     = !(state_d inside {S_IDLE, S_DONE, S_ERR});
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sec_data_q   <= 1'b0;
      cnt_hi_q     <= '0;
      count_q      <= '0;
      index_q      <= '0;
      shift_q      <= '0;
      byte_cnt_q   <= '0;
      in_ready_q   <= 1'b0;
      instr_q      <= '0;
      instr_addr_q <= '0;
      instr_en_q   <= 1'b0;
      data_q       <= '0;
      data_addr_q  <= '0;
      data_en_q    <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sec_data_q   <= sec_data_d;
      cnt_hi_q     <= cnt_hi_d;
      count_q      <= count_d;
      index_q      <= index_d;
      shift_q      <= shift_d;
      byte_cnt_q   <= byte_cnt_d;
      in_ready_q   <= in_ready_d;
      instr_q      <= instr_d;
      instr_addr_q <= instr_addr_d;
      instr_en_q   <= instr_en_d;
      data_q       <= data_d;
      data_addr_q  <= data_addr_d;
      data_en_q    <= data_en_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign ldr.in_ready       = in_ready_q;
  assign ldr.ext_instr      = instr_q;
  assign ldr.ext_instr_addr = instr_addr_q;
  assign ldr.ext_instr_en   = instr_en_q;
  assign ldr.ext_data       = data_q;
  assign ldr.ext_data_addr  = data_addr_q;
  assign ldr.ext_data_en    = data_en_q;
  assign ldr.start          = start_q;
  assign ldr.busy           = busy_q;
  assign ldr.done           = done_q;
  assign ldr.error          = error_q;

endmodule

// File: tb/tb_mips_program_loader.sv
// Directed bench for mips_program_loader: expected writes/start go into a queue
// as bytes are sent and are matched against strobes seen on the CPU side.
module tb_mips_program_loader;

  localparam logic [31:0] INSTR_BASE = 32'h0000_0000;
  localparam logic [31:0] DATA_BASE  = 32'h0000_0100;
  localparam int unsigned MAX_WORDS  = 256;

  typedef struct packed {
    logic [1:0]  kind;   // 0 instr, 1 data, 2 start
    logic [31:0] addr;
    logic [31:0] word;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] cyc = '0;
  logic [31:0] hs_cyc = '0;
  bit   rnd_mode = 1'b0;
  exp_t exp_q[$];

  mips_program_loader_if bus ();

  mips_program_loader #(
    .INSTR_BASE (INSTR_BASE),
    .DATA_BASE  (DATA_BASE),
    .MAX_WORDS  (MAX_WORDS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ldr   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Match every strobe or start pulse against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (bus.ext_instr_en || bus.ext_data_en || bus.start)) begin
      exp_t e;
      logic [1:0] kind;
      chk("one_hot", 32'(int'(bus.ext_instr_en) + int'(bus.ext_data_en) + int'(bus.start)), 32'd1);
      chk("ready_low_on_strobe", 32'(bus.in_ready), 32'd0);
      kind = bus.start ? 2'd2 : (bus.ext_data_en ? 2'd1 : 2'd0);
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_strobe obs=kind%0d exp=none", kind);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("strobe_kind", 32'(kind), 32'(e.kind));
        chk("strobe_cycle", cyc, e.cyc);
        if (kind == 2'd1) begin
          chk("data_addr", bus.ext_data_addr, e.addr);
          chk("data_word", bus.ext_data, e.word);
        end else if (kind == 2'd0) begin
          chk("instr_addr", bus.ext_instr_addr, e.addr);
          chk("instr_word", bus.ext_instr, e.word);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    if (rnd_mode) begin
      while ($urandom_range(1, 0) == 1) begin
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_timeout", 32'(guard < 50), 32'd1);
    hs_cyc = cyc + 32'd1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'($urandom);
  endtask

  task automatic send_word(input logic [1:0] kind, input logic [31:0] addr, input logic [31:0] w);
    exp_t e;
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
    e.kind = kind; e.addr = addr; e.word = w; e.cyc = hs_cyc;
    exp_q.push_back(e);
  endtask

  task automatic send_go();
    exp_t e;
    send_byte(8'hFF);
    e.kind = 2'd2; e.addr = '0; e.word = '0; e.cyc = hs_cyc;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_flags", 32'({bus.in_ready, bus.ext_instr_en, bus.ext_data_en, bus.start,
                          bus.busy, bus.done, bus.error}), 32'd0);
    chk("rst_buses", bus.ext_instr | bus.ext_instr_addr | bus.ext_data | bus.ext_data_addr, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic scenario1();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
    send_word(2'd0, INSTR_BASE + 32'd0, 32'h3C08_0010);
    send_word(2'd0, INSTR_BASE + 32'd4, 32'h8D09_0004);
    idle(3);
    chk("s1_queue_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk("s1_back_idle", 32'({bus.in_ready, bus.busy, bus.done, bus.error}), 32'b1000);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_byte  = 8'h00;
    bus.in_valid = 1'b0;
    idle(2);
    do_reset();

    scenario1();

    // Zero-count section is skipped, then one data word.
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
    send_word(2'd1, DATA_BASE, 32'h0000_002A);
    idle(3);
    chk("s3_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("s3_instr_held", bus.ext_instr, 32'h8D09_0004);
    chk("s3_instr_addr_held", bus.ext_instr_addr, 32'h0000_0004);

    // Data section restarts at DATA_BASE, then GO.
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
    send_word(2'd1, DATA_BASE, 32'hDEAD_BEEF);
    send_go();
    idle(4);
    chk("s2_queue_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk("s2_done", 32'({bus.done, bus.in_ready, bus.busy, bus.error, bus.start}), 32'b10000);
    chk("s2_data_held", bus.ext_data, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    // Random in_valid gaps do not change values or strobe timing.
    do_reset();
    rnd_mode = 1'b1;
    scenario1();
    rnd_mode = 1'b0;

    // Reset in the middle of a word, then replay.
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h3C); send_byte(8'h08);
    do_reset();
    chk("s5_no_pending", 32'(exp_q.size()), 32'd0);
    scenario1();

    // Bad command byte, then GO attempts are ignored.
    send_byte(8'h37);
    idle(1);
    bus.in_byte = 8'hFF; bus.in_valid = 1'b1;
    idle(5);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("s4_bad_cmd_err", 32'({bus.error, bus.in_ready, bus.busy, bus.done}), 32'b1000);
    @(posedge clk); #1;

    // Count 257 exceeds the limit.
    do_reset();
    send_byte(8'h01); send_byte(8'h01); send_byte(8'h01);
    idle(1);
    bus.in_byte = 8'hFF; bus.in_valid = 1'b1;
    idle(5);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("s4_overflow_err", 32'({bus.error, bus.in_ready, bus.busy, bus.done}), 32'b1000);
    chk("s4_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;

    // Max-size count is accepted: one word written, then stall.
    do_reset();
    send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
    send_word(2'd0, INSTR_BASE, 32'h1234_5678);
    idle(3);
    @(negedge clk);
    chk("max_count_busy", 32'({bus.error, bus.busy, bus.in_ready}), 32'b011);
    chk("max_count_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
